// File: rtl/keypad_pkg.sv
// Shared types, key constants and one-hot helpers for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} scan_state_t;

   typedef logic [3:0] key_code_t;

   localparam key_code_t KEY_SUBMIT_LETTER = 4'b1100;
   localparam key_code_t KEY_SUBMIT_WORD   = 4'b1110;

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   // row[3] is R0, so the row index counts down from the MSB
   function automatic logic [1:0] row_index(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b1000: idx = 2'd0;
         4'b0100: idx = 2'd1;
         4'b0010: idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   function automatic logic [1:0] col_index(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous level inputs, async active-low reset.
module keypad_sync #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobing, press/release debounce, and multi-tap
// index tracking for repeated presses of the same key.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_CYCLES     = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 8,
   parameter int unsigned TAP_WINDOW      = 64,
   parameter int unsigned MAX_TAPS        = 4
) (
   input  logic                        clk,
   input  logic                        nRst,
   input  logic [3:0]                  row,
   output logic [3:0]                  cols,
   output logic                        key_strobe,
   output key_code_t                   key_code,
   output logic [$clog2(MAX_TAPS)-1:0] key_tap,
   output logic                        key_held
);

   localparam int unsigned DWELL_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TMR_W   = $clog2(TAP_WINDOW + 1);
   localparam int unsigned TAP_W   = $clog2(MAX_TAPS);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0]   TMR_MAX    = TMR_W'(TAP_WINDOW);
   localparam logic [TAP_W-1:0]   TAP_LAST   = TAP_W'(MAX_TAPS - 1);

   logic [3:0]         srow;
   scan_state_t        state;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [DEB_W-1:0]   deb_cnt;
   logic [TMR_W-1:0]   tap_tmr;
   logic [3:0]         cap_row;
   key_code_t          cap_code;
   logic [TAP_W-1:0]   tap_next;

   keypad_sync #(.WIDTH(4)) u_row_sync (
      .clk  (clk),
      .nRst (nRst),
      .d    (row),
      .q    (srow)
   );

   // key_code resets to 0 but the timer starts saturated, so the first press is tap 0
   always_comb begin
      tap_next = '0;
      if ((cap_code == key_code) && (tap_tmr < TMR_MAX))
         tap_next = (key_tap == TAP_LAST) ? '0 : key_tap + TAP_W'(1);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state      <= SCAN;
         cols       <= 4'b0001;
         dwell_cnt  <= '0;
         deb_cnt    <= '0;
         cap_row    <= '0;
         cap_code   <= '0;
         tap_tmr    <= TMR_MAX;
         key_strobe <= 1'b0;
         key_code   <= '0;
         key_tap    <= '0;
         key_held   <= 1'b0;
      end else begin
         key_strobe <= 1'b0;
         if (tap_tmr < TMR_MAX)
            tap_tmr <= tap_tmr + TMR_W'(1);

         case (state)
            SCAN: begin
               if (dwell_cnt == DWELL_LAST) begin
                  dwell_cnt <= '0;
                  if (is_one_hot(srow)) begin
                     cap_row  <= srow;
                     cap_code <= {row_index(srow), col_index(cols)};
                     deb_cnt  <= '0;
                     state    <= DEBOUNCE;
                  end else begin
                     cols <= {cols[2:0], cols[3]};
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + DWELL_W'(1);
               end
            end

            DEBOUNCE: begin
               if (srow != cap_row) begin
                  state <= SCAN;
               end else if (deb_cnt == DEB_LAST) begin
                  deb_cnt    <= '0;
                  key_strobe <= 1'b1;
                  key_code   <= cap_code;
                  key_tap    <= tap_next;
                  key_held   <= 1'b1;
                  tap_tmr    <= '0;
                  state      <= HELD;
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end

            HELD: begin
               if (srow != 4'b0000) begin
                  deb_cnt <= '0;
               end else if (deb_cnt == DEB_LAST) begin
                  deb_cnt  <= '0;
                  key_held <= 1'b0;
                  state    <= SCAN;
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end

            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a column-aware keypad model.
module tb_keypad_scan_ctrl;
   import keypad_pkg::*;

   logic       tb_clk;
   logic       nRst;
   logic [3:0] row;
   logic [3:0] cols;
   logic       key_strobe;
   key_code_t  key_code;
   logic [1:0] key_tap;
   logic       key_held;

   logic       key_down;
   logic [1:0] key_r;
   logic [1:0] key_c;
   logic       ovr_en;
   logic [3:0] ovr_row;

   int n_checks;
   int n_errors;
   int strobe_cnt;

   keypad_scan_ctrl #(
      .SCAN_CYCLES     (4),
      .DEBOUNCE_CYCLES (8),
      .TAP_WINDOW      (64),
      .MAX_TAPS        (4)
   ) dut (
      .clk        (tb_clk),
      .nRst       (nRst),
      .row        (row),
      .cols       (cols),
      .key_strobe (key_strobe),
      .key_code   (key_code),
      .key_tap    (key_tap),
      .key_held   (key_held)
   );

   // a pressed key only returns on its row while its own column is driven
   assign row = ovr_en ? ovr_row :
                (key_down && cols[key_c]) ? (4'b1000 >> key_r) : 4'b0000;

   initial begin
      tb_clk = 1'b0;
      forever #5 tb_clk = ~tb_clk;
   end

   initial strobe_cnt = 0;
   always @(posedge tb_clk) begin
      #1;
      if (key_strobe) strobe_cnt = strobe_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tap_key(input string tag, input logic [1:0] r, input logic [1:0] c,
                          input int hold, input logic [3:0] exp_code, input logic [1:0] exp_tap);
      int base;
      int cyc;
      base = strobe_cnt;
      key_r = r;
      key_c = c;
      key_down = 1'b1;
      cyc = 0;
      while (strobe_cnt == base && cyc < 100) begin
         @(negedge tb_clk);
         cyc++;
      end
      check_val({tag, "_strobe"}, strobe_cnt - base, 1);
      check_val({tag, "_code"}, key_code, exp_code);
      check_val({tag, "_tap"}, key_tap, exp_tap);
      check_val({tag, "_held"}, key_held, 1);
      @(negedge tb_clk);
      check_val({tag, "_pulse"}, key_strobe, 0);
      repeat (hold) @(negedge tb_clk);
      key_down = 1'b0;
      cyc = 0;
      while (key_held && cyc < 40) begin
         @(negedge tb_clk);
         cyc++;
      end
      check_val({tag, "_rel"}, cyc, 10);
      check_val({tag, "_once"}, strobe_cnt - base, 1);
      repeat (2) @(negedge tb_clk);
   endtask

   initial begin
      int base;
      int cyc;
      logic [3:0] prev_cols;
      logic [3:0] exp_cols;

      n_checks = 0;
      n_errors = 0;
      nRst     = 1'b0;
      key_down = 1'b0;
      key_r    = 2'd0;
      key_c    = 2'd0;
      ovr_en   = 1'b0;
      ovr_row  = 4'b0000;

      // reset state
      repeat (3) @(negedge tb_clk);
      check_val("rst_cols", cols, 4'b0001);
      check_val("rst_strobe", key_strobe, 0);
      check_val("rst_code", key_code, 0);
      check_val("rst_tap", key_tap, 0);
      check_val("rst_held", key_held, 0);

      // idle scan rotation: column advances every 4 cycles
      nRst = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge tb_clk);
         exp_cols = 4'b0001 << ((n / 4) % 4);
         check_val("scan_cols", cols, exp_cols);
      end
      repeat (24) @(negedge tb_clk);
      check_val("idle_strobes", strobe_cnt, 0);
      check_val("idle_held", key_held, 0);

      // R0C1 held 30 cycles
      tap_key("r0c1", 2'd0, 2'd1, 30, 4'b0001, 2'd0);
      prev_cols = cols;
      cyc = 0;
      while (cols == prev_cols && cyc < 20) begin
         @(negedge tb_clk);
         cyc++;
      end
      check_val("resume_scan", (cols != prev_cols), 1);

      // 3-cycle bounce on R0 during the C1 sample window
      base = strobe_cnt;
      cyc = 0;
      prev_cols = cols;
      while (!(cols == 4'b0010 && prev_cols != 4'b0010) && cyc < 40) begin
         prev_cols = cols;
         @(negedge tb_clk);
         cyc++;
      end
      check_val("find_c1", cols, 4'b0010);
      ovr_row = 4'b1000;
      ovr_en  = 1'b1;
      repeat (3) @(negedge tb_clk);
      ovr_en  = 1'b0;
      repeat (40) @(negedge tb_clk);
      check_val("bounce_strobes", strobe_cnt - base, 0);
      check_val("bounce_held", key_held, 0);

      // two rows at once is a chord/ghost and must be ignored
      base = strobe_cnt;
      ovr_row = 4'b1010;
      ovr_en  = 1'b1;
      repeat (40) @(negedge tb_clk);
      ovr_en  = 1'b0;
      repeat (12) @(negedge tb_clk);
      check_val("ghost_strobes", strobe_cnt - base, 0);
      check_val("ghost_held", key_held, 0);
      check_val("code_kept", key_code, 4'b0001);

      // multi-tap on R1C1: index wraps after 4
      tap_key("tap0", 2'd1, 2'd1, 5, 4'b0101, 2'd0);
      tap_key("tap1", 2'd1, 2'd1, 5, 4'b0101, 2'd1);
      tap_key("tap2", 2'd1, 2'd1, 5, 4'b0101, 2'd2);
      tap_key("tap3", 2'd1, 2'd1, 5, 4'b0101, 2'd3);
      tap_key("tap4", 2'd1, 2'd1, 5, 4'b0101, 2'd0);
      repeat (100) @(negedge tb_clk);
      tap_key("tap_late", 2'd1, 2'd1, 5, 4'b0101, 2'd0);

      // different key inside the window restarts the index
      repeat (80) @(negedge tb_clk);
      tap_key("r1c1", 2'd1, 2'd1, 5, 4'b0101, 2'd0);
      tap_key("r2c0", 2'd2, 2'd0, 5, 4'b1000, 2'd0);

      // submit keys
      tap_key("sub_letter", 2'd3, 2'd0, 5, KEY_SUBMIT_LETTER, 2'd0);
      tap_key("sub_word", 2'd3, 2'd2, 5, KEY_SUBMIT_WORD, 2'd0);

      // reset while HELD
      base = strobe_cnt;
      key_r = 2'd1;
      key_c = 2'd1;
      key_down = 1'b1;
      cyc = 0;
      while (strobe_cnt == base && cyc < 100) begin
         @(negedge tb_clk);
         cyc++;
      end
      check_val("hreset_press", strobe_cnt - base, 1);
      repeat (3) @(negedge tb_clk);
      nRst = 1'b0;
      #1;
      check_val("hreset_cols", cols, 4'b0001);
      check_val("hreset_held", key_held, 0);
      check_val("hreset_code", key_code, 0);
      check_val("hreset_tap", key_tap, 0);
      key_down = 1'b0;
      repeat (3) @(negedge tb_clk);
      nRst = 1'b1;
      repeat (40) @(negedge tb_clk);
      check_val("hreset_quiet", strobe_cnt - base, 1);
      // code 0 matches the reset key_code, but the saturated timer keeps tap at 0
      tap_key("post_rst", 2'd0, 2'd0, 5, 4'b0000, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences one 4x4 matrix keypad, either host side or player side; the top level instantiates two.
- Drives one-hot column strobes, samples the 4-bit row return, debounces it, and emits one single-cycle strobe per key press with a 4-bit key code.
- Tracks consecutive presses of the same key within a time window and reports a tap index, so the downstream letter-entry logic can do multi-tap letter selection (e.g. 'L' = third tap).

Parameters:
- SCAN_CYCLES, 4, clock cycles each column stays driven (dwell).
- DEBOUNCE_CYCLES, 8, consecutive stable cycles needed to accept a press or a release.
- TAP_WINDOW, 64, maximum cycles from one strobe to the next for that press to count as a repeat tap.
- MAX_TAPS, 4, tap index modulus; the index wraps to 0.

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous reset, active-low.
- row  in  4  raw keypad row return, active-high, asynchronous to clk. row[3]=R0 … row[0]=R3.
- cols  out  4  one-hot column strobe, active-high. cols[0]=C0 … cols[3]=C3.
- key_strobe  out  1  one-cycle pulse for each accepted press.
- key_code  out  4  {row_idx[1:0], col_idx[1:0]}; valid when key_strobe=1 and held until the next strobe.
- key_tap  out  $clog2(MAX_TAPS)  tap index for the press; updated together with key_strobe.
- key_held  out  1  high while an accepted key is still down or its release is being debounced.

Behaviour:
- Reset (async, nRst=0): cols=4'b0001, key_strobe=0, key_code=0, key_tap=0, key_held=0, state=SCAN, dwell counter=0, debounce counter=0, tap timer saturated at TAP_WINDOW. Reset asserted in any state, including mid-debounce or HELD, aborts the operation. No strobe is emitted for an aborted press.
- row passes through a 2-flop synchronizer before use. Let srow be the synchronized value. Press-to-strobe latency is therefore 2 + (cycles to reach sample point) + DEBOUNCE_CYCLES + 1.
- SCAN:
  - Dwell counter counts 0..SCAN_CYCLES-1. At the wrap, cols rotates left: 0001→0010→0100→1000→0001.
  - srow is sampled only on the last dwell cycle, to allow settling.
  - Sample has exactly one bit set: capture row_idx = 3 − bit position and col_idx = active column, freeze cols, clear debounce counter, go to DEBOUNCE.
  - Sample has two or more bits set (ghosting/chord): ignore it and keep scanning.
- DEBOUNCE:
  - While srow equals the captured one-hot value, increment the debounce counter.
  - srow changes or goes to zero before the count completes: go to SCAN. cols resumes rotation from the frozen column; no strobe.
  - Count reaches DEBOUNCE_CYCLES: pulse key_strobe for one cycle, load key_code and key_tap, set key_held=1, go to HELD.
- HELD:
  - cols stays frozen.
  - srow==0 for DEBOUNCE_CYCLES consecutive cycles: key_held=0, go to SCAN. Any nonzero cycle restarts that count.
  - A key pressed while another is held produces no strobe.
- Tap logic:
  - Tap timer clears to 0 on each strobe, then increments each cycle and saturates at TAP_WINDOW.
  - On a strobe: if the new code equals the previous key_code and timer < TAP_WINDOW, key_tap = (key_tap+1) mod MAX_TAPS. Otherwise key_tap = 0.
  - The first press after reset always reports tap 0.
- Strobe and tap update happen in the same cycle; there is no back-pressure. The consumer must accept the strobe in that cycle.
- All counters are sized with $clog2 of their maximum value plus 1; none overflow.

Decomposition:
- keypad_pkg:
  - scan_state_t enum {SCAN, DEBOUNCE, HELD}.
  - key_code_t (logic [3:0]).
  - Named key constants used by the letter logic: KEY_SUBMIT_LETTER=4'b1100 (R3C0), KEY_SUBMIT_WORD=4'b1110 (R3C2).
- Sub-module keypad_sync: the parameterised-width 2-flop synchronizer with async active-low reset. It is reused for role_switch elsewhere.

Test Plan (bench parameters: SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, TAP_WINDOW=64, MAX_TAPS=4):
- Reset release, row=0 for 40 cycles → cols steps 0001,0010,0100,1000 every 4 cycles; no strobe; key_held=0.
- row=4'b1000 asserted while cols=0010, held 30 cycles then released → exactly one strobe, key_code=4'b0001, key_tap=0; key_held falls 8+2 cycles after release; scanning resumes.
- row=4'b1000 pulsed for 3 cycles during the C1 sample → no strobe; state returns to SCAN.
- R1C1 (row=0100 on cols=0010) pressed 5 times, 30 cycles apart → key_code=4'b0101 each time, key_tap=0,1,2,3,0. Then a sixth press 100 cycles later → key_tap=0.
- R1C1 then R2C0 within the window → second strobe key_code=4'b1000, key_tap=0.
- row=4'b1010 during scan → no strobe. Separately, nRst pulsed low while in HELD → cols=0001, key_held=0, key_code=0 immediately; no strobe after nRst rises until row goes 0 and a new press is debounced.
